// File: rtl/alu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: M-extension funct3 codes,
// R-type opcodes, FSM state encoding and operand-signedness helpers.
package alu_pkg;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   localparam logic [6:0] OP_RTYPE   = 7'b0110011;
   localparam logic [6:0] OP_RTYPE_W = 7'b0111011;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StFix,
      StDone
   } md_state_e;

   function automatic logic op_signed_a(input logic [2:0] f3);
      return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f3);
      return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling around the unsigned iterative core: operand magnitudes on entry,
// and negation, high/low selection and word sign-extension of the raw result on exit.
module md_sign_fix
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   input  logic [2:0]        funct3_i,
   input  logic              word_i,
   output logic [XLEN-1:0]   mag_a_o,
   output logic [XLEN-1:0]   mag_b_o,
   output logic              sign_a_o,
   output logic              sign_b_o,
   input  logic [2:0]        fix_funct3_i,
   input  logic              fix_word_i,
   input  logic              fix_sign_a_i,
   input  logic              fix_sign_b_i,
   // Multiply: full product. Divide: {remainder, quotient}.
   input  logic [2*XLEN-1:0] raw_i,
   output logic [XLEN-1:0]   res_o
);

   logic              sa, sb;
   logic [XLEN-1:0]   a_n, b_n;
   logic [2*XLEN-1:0] prod, prod_s, prod_hi;
   logic [XLEN-1:0]   quot, rem, val;

   always_comb begin
      sa = op_signed_a(funct3_i);
      sb = op_signed_b(funct3_i);
      a_n = a_i;
      b_n = b_i;
      if (word_i) begin
         a_n = sa ? XLEN'($signed(a_i[31:0])) : XLEN'(a_i[31:0]);
         b_n = sb ? XLEN'($signed(b_i[31:0])) : XLEN'(b_i[31:0]);
      end
      sign_a_o = sa & a_n[XLEN-1];
      sign_b_o = sb & b_n[XLEN-1];
      mag_a_o  = sign_a_o ? -a_n : a_n;
      mag_b_o  = sign_b_o ? -b_n : b_n;
   end

   always_comb begin
      // A word product lands 32 bits up in the shift register.
      prod    = fix_word_i ? (raw_i >> 32) : raw_i;
      prod_s  = (fix_sign_a_i ^ fix_sign_b_i) ? -prod : prod;
      prod_hi = prod_s >> (fix_word_i ? 32 : XLEN);
      quot    = (fix_sign_a_i ^ fix_sign_b_i) ? -raw_i[XLEN-1:0] : raw_i[XLEN-1:0];
      rem     = fix_sign_a_i ? -raw_i[2*XLEN-1:XLEN] : raw_i[2*XLEN-1:XLEN];
      val     = '0;
      unique case (fix_funct3_i)
         MUL:                 val = prod_s[XLEN-1:0];
         MULH, MULHSU, MULHU: val = prod_hi[XLEN-1:0];
         DIV, DIVU:           val = quot;
         REM, REMU:           val = rem;
         default:             val = '0;
      endcase
      res_o = fix_word_i ? XLEN'($signed(val[31:0])) : val;
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit for RV M (and *W ops), with a
// valid/ready start handshake, early-out special cases and flush.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 64,
   parameter bit          W_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      funct3,
   input  logic            word,
   input  logic            kill,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam bit          WordEn = W_EN && (XLEN == 64);
   localparam int unsigned CntW   = $clog2(XLEN);

   md_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN:0]   acc_q, acc_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            word_q, word_d;
   logic            sign_a_q, sign_a_d;
   logic            sign_b_q, sign_b_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            word_in, accept;
   logic [XLEN-1:0] mag_a, mag_b, fix_res;
   logic            sign_a, sign_b;
   logic            b_zero, a_min, b_ones, div_zero, div_ovf;
   logic [XLEN-1:0] early_raw, early_res;
   logic [XLEN:0]   mul_sum, rem_sh;
   logic            div_ge;

   assign word_in = word & WordEn;
   assign ready   = (state_q == StIdle) || (state_q == StDone);
   assign done    = (state_q == StDone);
   assign result  = result_q;
   assign accept  = start & ready & ~kill;

   md_sign_fix #(
      .XLEN (XLEN)
   ) u_sign_fix (
      .a_i          (a),
      .b_i          (b),
      .funct3_i     (funct3),
      .word_i       (word_in),
      .mag_a_o      (mag_a),
      .mag_b_o      (mag_b),
      .sign_a_o     (sign_a),
      .sign_b_o     (sign_b),
      .fix_funct3_i (funct3_q),
      .fix_word_i   (word_q),
      .fix_sign_a_i (sign_a_q),
      .fix_sign_b_i (sign_b_q),
      .raw_i        ({acc_q[XLEN-1:0], lo_q}),
      .res_o        (fix_res)
   );

   always_comb begin
      b_zero   = word_in ? (b[31:0] == 32'h0) : (b == '0);
      a_min    = word_in ? (a[31:0] == 32'h8000_0000) : (a == {1'b1, {(XLEN-1){1'b0}}});
      b_ones   = word_in ? (&b[31:0]) : (&b);
      div_zero = funct3[2] & b_zero;
      // Only DIV and REM (funct3[0] clear) can overflow.
      div_ovf  = funct3[2] & ~funct3[0] & a_min & b_ones;
      if (div_zero) begin
         early_raw = funct3[1] ? a : '1;
      end else begin
         early_raw = funct3[1] ? '0 : a;
      end
      early_res = word_in ? XLEN'($signed(early_raw[31:0])) : early_raw;
   end

   assign mul_sum = acc_q + (lo_q[0] ? {1'b0, opb_q} : '0);
   assign rem_sh  = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
   assign div_ge  = rem_sh >= {1'b0, opb_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      funct3_d = funct3_q;
      word_d   = word_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      result_d = result_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (accept) begin
               funct3_d = funct3;
               word_d   = word_in;
               sign_a_d = sign_a;
               sign_b_d = sign_b;
               cnt_d    = word_in ? CntW'(31) : CntW'(XLEN - 1);
               acc_d    = '0;
               if (funct3[2]) begin
                  // Word dividends are pre-aligned so their MSB is shifted out first.
                  lo_d  = word_in ? (mag_a << 32) : mag_a;
                  opb_d = mag_b;
               end else begin
                  lo_d  = mag_b;
                  opb_d = mag_a;
               end
               if (div_zero || div_ovf) begin
                  result_d = early_res;
                  state_d  = StDone;
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (funct3_q[2]) begin
               acc_d = div_ge ? (rem_sh - {1'b0, opb_q}) : rem_sh;
               lo_d  = {lo_q[XLEN-2:0], div_ge};
            end else begin
               acc_d = {1'b0, mul_sum[XLEN:1]};
               lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
            end
            if (cnt_q == '0) begin
               state_d = StFix;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StFix: begin
            result_d = fix_res;
            state_d  = StDone;
         end
         default: state_d = StIdle;
      endcase

      if (kill) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         funct3_q <= '0;
         word_q   <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         funct3_q <= funct3_d;
         word_q   <= word_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         result_q <= result_d;
      end
   end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the RV M/M64 extension. Sits in the hart's execute stage beside the single-cycle integer ALU.
- Accepts one operation at a time through a valid/ready handshake and returns the result with a one-cycle done pulse.
- Generalised over XLEN, and covers the word (W) variants.
- Adds multi-cycle sequencing, early-out special cases and flush support, none of which the combinational ALU has.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- W_EN, 1, enables the *W word ops; forced to 0 when XLEN=32.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request valid.
- ready  out  1  unit can accept an operation this cycle.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- funct3  in  3  M-extension funct3 (MUL..REMU).
- word  in  1  *W variant (opcode 0111011); ignored when W_EN=0.
- kill  in  1  pipeline flush; aborts any in-flight op.
- done  out  1  one-cycle pulse, result valid.
- result  out  XLEN  result; held stable until the next accept.

Behaviour:
- Reset (async, rst=1): state IDLE, ready=1, done=0, result=0, counter=0, internal registers cleared.
- States:
  - IDLE: ready=1.
  - BUSY: ready=0.
  - FIX: ready=0, one cycle of sign correction.
  - DONE: ready=1, done=1 for exactly one cycle.
- Accept occurs on start & ready & !kill. On accept, latch operands, funct3 and word, and go to BUSY. From DONE, an accept goes directly to BUSY (back-to-back issue).
- Without an accept, DONE returns to IDLE. result holds its value.
- Operand conditioning:
  - N = 32 for word ops, otherwise XLEN.
  - Word ops use a[31:0], b[31:0], sign- or zero-extended per op signedness.
  - Signed ops convert to magnitudes; record sign_a, sign_b.
  - MULHSU treats a as signed and b as unsigned.
- Multiply: radix-2 shift-add, one bit per cycle over N cycles, into a 2N-bit product.
  - MUL returns product[N-1:0].
  - MULH, MULHSU and MULHU return product[2N-1:N].
  - Product negated in FIX when sign_a^sign_b (signed operand set only).
- Divide: restoring, one quotient bit per cycle over N cycles.
  - Quotient negated when sign_a^sign_b.
  - Remainder takes the sign of the dividend.
- Latency:
  - Normal ops: BUSY for N cycles, then FIX for 1 cycle. done rises N+1 cycles after the accept edge (65 for XLEN=64, 33 for word ops).
- Early-out cases (checked at accept; skip BUSY and FIX; done on the next cycle):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (most-negative / -1): DIV gives most-negative; REM gives 0.
  - Either early-out applies to the word width when word=1.
- Word result: bits [XLEN-1:32] are a sign-extension of bit 31, for every word op.
- kill:
  - In any state, the next state is IDLE. done stays 0 and result is not updated.
  - kill in the same cycle as start means no accept.
  - kill in the DONE cycle does not retract the done already asserted.
- start while ready=0 is ignored (no queueing). Upstream holds start until ready.
- Reset asserted mid-operation aborts immediately. done is never asserted for the aborted op.

Decomposition:
- Shared package alu_pkg holds:
  - funct3 constants: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - Opcode constants OP_RTYPE=0110011, OP_RTYPE_W=0111011.
  - FSM state encoding IDLE/BUSY/FIX/DONE.
- One natural sub-module: md_sign_fix. It is combinational and contains magnitude conversion on entry, and conditional negation, high/low select and word sign-extension on exit. The FSM, counter and shift datapath stay in alu_muldiv.

Test Plan:
- MUL a=7, b=-3, XLEN=64 -> done after 65 cycles, result=0xFFFFFFFFFFFFFFEB. MULHU a=b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
- DIV a=-20, b=3 -> quotient -6 (0xFFFFFFFFFFFFFFFA). REM on the same operands -> -2. Both with 65-cycle latency.
- Divide by zero: DIVU a=5, b=0 -> 0xFFFFFFFFFFFFFFFF. REM a=5, b=0 -> 5. done one cycle after accept.
- Overflow: DIV a=0x8000000000000000, b=-1 -> 0x8000000000000000; REM -> 0. DIVW a=0x80000000, b=0xFFFFFFFF -> 0xFFFFFFFF80000000.
- MULW a=0x10000, b=0x8000 -> 0xFFFFFFFF80000000 after 33 cycles. Back-to-back start in the DONE cycle accepted, ready=0 in the following cycle.
- kill asserted 10 cycles into a DIV -> IDLE next cycle, ready=1, no done pulse, result unchanged. rst pulse mid-MUL -> all outputs at reset values asynchronously.
